// File: rtl/issue_scoreboard.sv
// issue_scoreboard: pending-write scoreboard gating decode->execute issue
// on RAW/WAW hazards, execute backpressure and an in-flight limit.
// Ports: CLK, RESET (async, active-high)
//   in : DE_V, DE_IR[31:0], EX_READY, WB_V, WB_RD[4:0]
//   out: ISSUE, stall (comb); PENDING[31:0], INFLIGHT, STALL_CYCLES, ERR (reg)
module issue_scoreboard #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             DE_V,
  input  logic [31:0]      DE_IR,
  input  logic             EX_READY,
  input  logic             WB_V,
  input  logic [4:0]       WB_RD,
  output logic             ISSUE,
  output logic             stall,
  output logic [31:0]      PENDING,
  output logic [CNT_W-1:0] INFLIGHT,
  output logic [15:0]      STALL_CYCLES,
  output logic             ERR
);

  logic [6:0]       w_op;
  logic [4:0]       w_rd;
  logic [4:0]       w_rs1;
  logic [4:0]       w_rs2;
  logic             w_use1;
  logic             w_use2;
  logic             w_wr_op;
  logic             w_wr;
  logic [31:0]      w_wb_mask;
  logic [31:0]      w_eff;
  logic [31:0]      w_set;
  logic [31:0]      w_clr;
  logic             w_ret;
  logic             w_hazard;
  logic             w_full;
  logic [CNT_W-1:0] w_cnt_after;
  logic             w_unused;

  assign w_op  = DE_IR[6:0];
  assign w_rd  = DE_IR[11:7];
  assign w_rs1 = DE_IR[19:15];
  assign w_rs2 = DE_IR[24:20];

  assign w_unused = ^{DE_IR[31:25], DE_IR[14:12]};

  always_comb begin
    w_use1  = 1'b0;
    w_use2  = 1'b0;
    w_wr_op = 1'b0;
    case (w_op)
      7'b0000011: begin
        w_use1  = 1'b1;
        w_wr_op = 1'b1;
      end
      7'b0100011: begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
      end
      7'b0110011: begin
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_wr_op = 1'b1;
      end
      7'b1100011: begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
      end
      7'b0010011,
      7'b1100111: begin
        w_use1  = 1'b1;
        w_wr_op = 1'b1;
      end
      7'b0110111,
      7'b0010111,
      7'b1101111: w_wr_op = 1'b1;
      default: ;
    endcase
  end

  assign w_wr = w_wr_op && (w_rd != 5'd0);

  // Same-cycle writeback hides the pending bit: regfile writes before read.
  assign w_wb_mask = WB_V ? (32'd1 << WB_RD) : 32'd0;
  assign w_eff     = PENDING & ~w_wb_mask;

  assign w_hazard = (w_use1 && w_eff[w_rs1])
                 || (w_use2 && w_eff[w_rs2])
                 || (w_wr   && w_eff[w_rd]);

  // A retirement never underflows the count; an empty retire is an error.
  assign w_ret       = WB_V && (INFLIGHT != '0);
  assign w_cnt_after = INFLIGHT - {{(CNT_W-1){1'b0}}, w_ret};
  assign w_full      = (w_cnt_after == CNT_W'(MAX_INFLIGHT));

  assign ISSUE = DE_V && EX_READY && !w_hazard && !w_full;
  assign stall = DE_V && !ISSUE;

  assign w_set = (ISSUE && w_wr) ? (32'd1 << w_rd) : 32'd0;
  assign w_clr = w_wb_mask & ~32'd1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PENDING      <= 32'd0;
      INFLIGHT     <= '0;
      STALL_CYCLES <= 16'd0;
      ERR          <= 1'b0;
    end else begin
      // Set is applied after clear so a re-issue to the retiring rd wins.
      PENDING  <= ((PENDING & ~w_clr) | w_set) & ~32'd1;
      INFLIGHT <= w_cnt_after + {{(CNT_W-1){1'b0}}, ISSUE};
      if (stall && (STALL_CYCLES != 16'hFFFF))
        STALL_CYCLES <= STALL_CYCLES + 16'd1;
      if (WB_V && ((INFLIGHT == '0) ||
                   ((WB_RD != 5'd0) && !PENDING[WB_RD])))
        ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: randomized + directed stimulus; expectations come
// from an in-flight instruction list model and are checked by a monitor.
module tb_issue_scoreboard;

  localparam int MAXI = 4;
  localparam int CW   = 4;

  logic          CLK;
  logic          RESET;
  logic          DE_V;
  logic [31:0]   DE_IR;
  logic          EX_READY;
  logic          WB_V;
  logic [4:0]    WB_RD;
  logic          ISSUE;
  logic          stall;
  logic [31:0]   PENDING;
  logic [CW-1:0] INFLIGHT;
  logic [15:0]   STALL_CYCLES;
  logic          ERR;

  issue_scoreboard #(.MAX_INFLIGHT(MAXI), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET), .DE_V(DE_V), .DE_IR(DE_IR),
    .EX_READY(EX_READY), .WB_V(WB_V), .WB_RD(WB_RD),
    .ISSUE(ISSUE), .stall(stall), .PENDING(PENDING),
    .INFLIGHT(INFLIGHT), .STALL_CYCLES(STALL_CYCLES), .ERR(ERR)
  );

  typedef struct {
    bit          issue;
    bit          stl;
    logic [31:0] pend;
    int          infl;
    int          scnt;
    bit          err;
  } exp_t;

  exp_t exp_q[$];
  int   inf_q[$];
  int   m_scnt;
  bit   m_err;
  int   n_vec;
  int   n_bad;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [31:0] ADD3 = 32'h002081B3;
  localparam logic [31:0] SUB4 = 32'h40118233;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] mk(logic [6:0] op, int rd, int rs1, int rs2);
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] c;
    a = rd[4:0];
    b = rs1[4:0];
    c = rs2[4:0];
    return {7'd0, c, b, 3'd0, a, op};
  endfunction

  function automatic bit pend(int r);
    if (r == 0) return 1'b0;
    foreach (inf_q[i]) if (inf_q[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] pvec();
    logic [31:0] v;
    v = '0;
    for (int r = 1; r < 32; r++) v[r] = pend(r);
    return v;
  endfunction

  task automatic model_reset();
    inf_q.delete();
    m_scnt = 0;
    m_err  = 1'b0;
  endtask

  task automatic cycle(input bit rst, input bit dv, input logic [31:0] ir,
                       input bit exr, input bit wbv, input int wbrd);
    exp_t e;
    logic [6:0] op;
    int rd, rs1, rs2, sz, k;
    bit u1, u2, wr, hz, full;
    @(negedge CLK);
    RESET = rst; DE_V = dv; DE_IR = ir; EX_READY = exr;
    WB_V = wbv; WB_RD = wbrd[4:0];
    if (rst) model_reset();
    op  = ir[6:0];
    rd  = int'(ir[11:7]);
    rs1 = int'(ir[19:15]);
    rs2 = int'(ir[24:20]);
    u1 = op inside {7'b0000011, 7'b0100011, 7'b0110011,
                    7'b1100011, 7'b0010011, 7'b1100111};
    u2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    wr = (op inside {7'b0000011, 7'b0110011, 7'b0010011, 7'b0110111,
                     7'b0010111, 7'b1101111, 7'b1100111}) && rd != 0;
    hz = (u1 && pend(rs1) && !(wbv && wbrd == rs1))
      || (u2 && pend(rs2) && !(wbv && wbrd == rs2))
      || (wr && pend(rd)  && !(wbv && wbrd == rd));
    sz = inf_q.size();
    full = (sz - ((wbv && sz > 0) ? 1 : 0)) == MAXI;
    e.issue = dv && exr && !hz && !full;
    e.stl   = dv && !e.issue;
    e.pend  = pvec();
    e.infl  = sz;
    e.scnt  = m_scnt;
    e.err   = m_err;
    exp_q.push_back(e);
    if (!rst) begin
      if (wbv) begin
        if (sz == 0) m_err = 1'b1;
        else begin
          if (wbrd != 0 && !pend(wbrd)) m_err = 1'b1;
          k = 0;
          foreach (inf_q[i]) if (inf_q[i] == wbrd) begin k = i; break; end
          inf_q.delete(k);
        end
      end
      if (e.issue) inf_q.push_back(wr ? rd : 0);
      if (e.stl && m_scnt < 65535) m_scnt++;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (ISSUE !== e.issue || stall !== e.stl || PENDING !== e.pend ||
            int'(INFLIGHT) != e.infl || int'(STALL_CYCLES) != e.scnt ||
            ERR !== e.err) begin
          n_bad++;
          if (n_bad <= 20)
            $display("FAIL vec %0d t=%0t: issue %b/%b stall %b/%b pend %h/%h infl %0d/%0d scnt %0d/%0d err %b/%b (got/exp)",
                     n_vec, $time, ISSUE, e.issue, stall, e.stl, PENDING, e.pend,
                     INFLIGHT, e.infl, STALL_CYCLES, e.scnt, ERR, e.err);
        end
      end
    end
  end

  initial begin : driver
    logic [6:0] ops [11];
    logic [31:0] ir;
    int idx;
    bit wbv;
    int wbrd;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011,
            7'b0001111};
    n_vec = 0;
    n_bad = 0;
    model_reset();
    RESET = 1'b1; DE_V = 1'b0; DE_IR = '0; EX_READY = 1'b0;
    WB_V = 1'b0; WB_RD = '0;

    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, ADD3, 1, 0, 0);
    // RAW with bypass on the writeback cycle
    cycle(0, 1, ADD3, 1, 0, 0);
    repeat (3) cycle(0, 1, SUB4, 1, 0, 0);
    cycle(0, 1, SUB4, 1, 1, 3);
    cycle(0, 0, 0, 1, 1, 4);
    // WAW behind a load, then a write to x0
    cycle(0, 1, mk(OP_LOAD, 5, 1, 0), 1, 0, 0);
    repeat (2) cycle(0, 1, mk(OP_IMM, 5, 0, 0), 1, 0, 0);
    cycle(0, 1, mk(OP_IMM, 5, 0, 0), 1, 1, 5);
    cycle(0, 0, 0, 1, 1, 5);
    cycle(0, 1, mk(OP_IMM, 0, 5, 0), 1, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    // occupancy limit, retire+issue in the same cycle
    for (int r = 6; r < 10; r++) cycle(0, 1, mk(OP_LUI, r, 0, 0), 1, 0, 0);
    cycle(0, 1, mk(OP_LUI, 10, 0, 0), 1, 0, 0);
    cycle(0, 1, mk(OP_LUI, 10, 0, 0), 1, 1, 6);
    for (int r = 7; r < 11; r++) cycle(0, 0, 0, 1, 1, r);
    // retire with nothing in flight, then asynchronous reset pulse
    cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 1, 0, 0);
    #3 RESET = 1'b1;
    #1 RESET = 1'b0;
    model_reset();
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 1, ADD3, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);

    cycle(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      ir = $urandom;
      ir[6:0]   = ops[$urandom_range(0, 10)];
      ir[11:7]  = 5'($urandom_range(0, 7));
      ir[19:15] = 5'($urandom_range(0, 7));
      ir[24:20] = 5'($urandom_range(0, 7));
      wbv  = 1'b0;
      wbrd = 0;
      if (inf_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        idx  = $urandom_range(0, inf_q.size() - 1);
        wbv  = 1'b1;
        wbrd = inf_q[idx];
      end
      cycle(0, $urandom_range(0, 3) != 0, ir,
            $urandom_range(0, 3) != 0, wbv, wbrd);
    end

    // long backpressure to saturate the stall counter
    for (int n = 0; n < 70000; n++) cycle(0, 1, ADD3, 0, 0, 0);

    @(negedge CLK);
    #4;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d left, 0 expected", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Register-dependency scoreboard and issue controller between the decode stage and the execute stage. It tracks destination registers of every in-flight instruction and gates decode-to-execute issue on RAW and WAW hazards, execute backpressure, and an in-flight occupancy limit. It replaces per-stage RD comparison with a single pending-bit vector cleared at writeback, so multi-cycle operations such as loads stall correctly for their full latency.

## Interface
- MAX_INFLIGHT, 4, maximum issued-but-not-retired instructions (1..15)
- CNT_W, 4, width of INFLIGHT counter; must hold MAX_INFLIGHT
- CLK  in  1  clock, all state on posedge
- RESET  in  1  asynchronous, active-high; clears all state immediately
- DE_V  in  1  decode holds a valid instruction
- DE_IR  in  32  decode instruction word
- EX_READY  in  1  execute can accept an instruction this cycle
- WB_V  in  1  one instruction retires this cycle; asserted for every retiring instruction
- WB_RD  in  5  destination of retiring instruction; 0 when it writes no register
- ISSUE  out  1  combinational; instruction in decode advances to execute this cycle
- stall  out  1  combinational; DE_V && !ISSUE
- PENDING  out  32  registered pending-write vector, bit i = xi awaiting writeback; bit 0 always 0
- INFLIGHT  out  CNT_W  registered issued-not-retired count
- STALL_CYCLES  out  16  registered saturating count of cycles with stall=1
- ERR  out  1  registered sticky protocol error

## Operation
- Decode fields: opcode=DE_IR[6:0], rd=[11:7], rs1=[19:15], rs2=[24:20].
- uses_rs1: opcodes 0000011, 0100011, 0110011, 1100011, 0010011, 1100111.
- uses_rs2: 0110011, 0100011, 1100011.
- writes_rd: 0000011, 0110011, 0010011, 0110111, 0010111, 1101111, 1100111, and rd!=0.
- Unknown opcodes: no reads, no write; issue subject only to EX_READY and occupancy.
- Effective pending: eff[i] = PENDING[i] && !(WB_V && WB_RD==i); same-cycle writeback is bypassed (register file writes before read).
- Register x0 never pending; reads of x0 never hazard.
- hazard = (uses_rs1 && eff[rs1]) || (uses_rs2 && eff[rs2]) || (writes_rd && eff[rd]).
- full = (INFLIGHT - (WB_V && INFLIGHT!=0)) == MAX_INFLIGHT.
- ISSUE = DE_V && EX_READY && !hazard && !full.
- Next-state per posedge:
  - WB_V && WB_RD!=0: clear PENDING[WB_RD].
  - ISSUE && writes_rd: set PENDING[rd]; set wins over same-cycle clear of same register.
  - INFLIGHT += ISSUE; INFLIGHT -= (WB_V && INFLIGHT!=0); simultaneous issue and retire leaves it unchanged.
  - stall: STALL_CYCLES += 1, saturates at 0xFFFF.
  - ERR set (sticky until RESET) when: WB_V with INFLIGHT==0 (count stays 0), or WB_V with WB_RD!=0 and PENDING[WB_RD]==0.
- No internal FSM beyond this state; block is flow-through per instruction.

## Timing
- ISSUE/stall: zero latency, combinational from DE_IR, DE_V, EX_READY, WB_V, WB_RD and registered state.
- PENDING/INFLIGHT/STALL_CYCLES/ERR update one edge after the causing event.
- Back-to-back dependent: producer issued at edge N blocks consumer until the cycle its WB_V/WB_RD is presented; consumer issues in that same cycle via bypass.
- Reset values: PENDING=0, INFLIGHT=0, STALL_CYCLES=0, ERR=0; ISSUE/stall follow inputs (ISSUE=DE_V&&EX_READY&&known-safe, since nothing pending).
- RESET asserted mid-operation clears all state asynchronously; in-flight instructions are forgotten; retirements after release with empty scoreboard set ERR.
- EX_READY=0 holds decode; no state changes except stall counting and retirements.

## Test plan
- After reset, DE_V=1, DE_IR=add x3,x1,x2 (0x002081B3), EX_READY=1 -> ISSUE=1; next cycle PENDING=0x8, INFLIGHT=1.
- With x3 pending, issue sub x4,x3,x1 -> stall=1 each cycle, STALL_CYCLES increments; WB_V=1,WB_RD=3 same cycle -> ISSUE=1, PENDING ends 0x10.
- Load to x5 pending, addi x5,x0,1 (WAW) -> stall until WB_RD=5; addi x0,x5,0 never sets PENDING[0].
- MAX_INFLIGHT=4: issue 4 independent lui instructions, 5th stalls with full; same cycle WB_V=1,WB_RD=rd0 -> 5th issues, INFLIGHT stays 4.
- WB_V=1 with INFLIGHT=0 -> ERR=1 next edge, INFLIGHT=0; ERR persists until RESET pulse mid-cycle clears it asynchronously.
- Force stall 70000 cycles -> STALL_CYCLES saturates at 0xFFFF.
